// File: rtl/sum_pool.sv
// Windowed sum/mean pooling stage: accumulates POOL_SIZE accepted samples and
// emits one saturated result per window over a ready/valid stream.
package cnn1d_pkg;
   localparam int DATA_WIDTH = 16;
endpackage

module sum_pool #(
   parameter int DATA_WIDTH = cnn1d_pkg::DATA_WIDTH,
   parameter int POOL_SIZE  = 4,
   parameter bit AVERAGE    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  sum_ready_in,
   input  logic                  sum_valid_in,
   input  logic [DATA_WIDTH-1:0] sum_data_in,
   input  logic                  sum_ready_out,
   output logic                  sum_valid_out,
   output logic [DATA_WIDTH-1:0] sum_data_out
);

   localparam int CNT_WIDTH = $clog2(POOL_SIZE);
   localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
   localparam int SHIFT     = AVERAGE ? CNT_WIDTH : 0;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(POOL_SIZE - 1);

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0] total, shifted;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]       data_q, data_d, sat;
   logic                        valid_q, valid_d;
   logic                        window_last, in_fire, fits;

   assign window_last  = (cnt_q == CNT_LAST);
   // Only the window-closing sample waits on a pending, unaccepted result.
   assign sum_ready_in = ~rst & (~window_last | ~valid_q | sum_ready_out);
   assign in_fire      = sum_valid_in & sum_ready_in;

   assign total   = acc_q + {{CNT_WIDTH{sum_data_in[DATA_WIDTH-1]}}, sum_data_in};
   assign shifted = total >>> SHIFT;
   // Result fits when all bits above the output sign bit replicate it.
   assign fits    = (&shifted[ACC_WIDTH-1:DATA_WIDTH-1]) | ~(|shifted[ACC_WIDTH-1:DATA_WIDTH-1]);

   always_comb begin
      sat = shifted[DATA_WIDTH-1:0];
      if (!fits) begin
         sat = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (valid_q && sum_ready_out) begin
         valid_d = 1'b0;
      end
      if (in_fire) begin
         if (window_last) begin
            data_d  = sat;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            acc_d = total;
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign sum_valid_out = valid_q;
   assign sum_data_out  = data_q;

endmodule

// File: tb/tb_sum_pool.sv
// Bench for sum_pool: sum and average instances share one stimulus stream and
// are checked every cycle against a window/queue model plus literal results.
module tb_sum_pool;

   localparam int DW = 16;
   localparam int P  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          sum_valid_in;
   logic [DW-1:0] sum_data_in;
   logic          sum_ready_out;
   logic          ready_in_s, ready_in_a;
   logic          valid_out_s, valid_out_a;
   logic [DW-1:0] data_out_s, data_out_a;

   int vectors    = 0;
   int miscompares = 0;
   int dut_xfers  = 0;

   // model state
   bit model_init = 0;
   int win[$];
   bit exp_valid  = 0;
   int exp_data_s = 0;
   int exp_data_a = 0;

   always #5 clk = ~clk;

   sum_pool #(.DATA_WIDTH(DW), .POOL_SIZE(P), .AVERAGE(1'b0)) u_sum (
      .clk(clk), .rst(rst),
      .sum_ready_in(ready_in_s), .sum_valid_in(sum_valid_in), .sum_data_in(sum_data_in),
      .sum_ready_out(sum_ready_out), .sum_valid_out(valid_out_s), .sum_data_out(data_out_s)
   );

   sum_pool #(.DATA_WIDTH(DW), .POOL_SIZE(P), .AVERAGE(1'b1)) u_avg (
      .clk(clk), .rst(rst),
      .sum_ready_in(ready_in_a), .sum_valid_in(sum_valid_in), .sum_data_in(sum_data_in),
      .sum_ready_out(sum_ready_out), .sum_valid_out(valid_out_a), .sum_data_out(data_out_a)
   );

   function automatic int clamp16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, then advance the model across the edge.
   always @(negedge clk) begin
      bit exp_ready;
      int s;
      exp_ready = !rst && ((win.size() != P-1) || !exp_valid || sum_ready_out);
      if (model_init) begin
         chk("ready_in_sum", 16'(ready_in_s), 16'(exp_ready));
         chk("ready_in_avg", 16'(ready_in_a), 16'(exp_ready));
         chk("valid_sum", 16'(valid_out_s), 16'(exp_valid));
         chk("valid_avg", 16'(valid_out_a), 16'(exp_valid));
         chk("data_sum", data_out_s, 16'(exp_data_s));
         chk("data_avg", data_out_a, 16'(exp_data_a));
      end
      if (valid_out_s && sum_ready_out) dut_xfers++;
      if (rst) begin
         model_init = 1;
         win.delete();
         exp_valid  = 0;
         exp_data_s = 0;
         exp_data_a = 0;
      end else if (model_init) begin
         if (exp_valid && sum_ready_out) exp_valid = 0;
         if (sum_valid_in && exp_ready) begin
            win.push_back(int'($signed(sum_data_in)));
            if (win.size() == P) begin
               s = 0;
               foreach (win[i]) s += win[i];
               exp_data_s = clamp16(s);
               exp_data_a = clamp16(floor_div(s, P));
               exp_valid  = 1;
               win.delete();
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic [DW-1:0] v);
      int n;
      n = 0;
      sum_valid_in = 1'b1;
      sum_data_in  = v;
      forever begin
         @(negedge clk);
         if (ready_in_s) break;
         n++;
         if (n > 50) begin
            miscompares++;
            $display("FAIL send_timeout: got ready_in 0 expected 1 within 50 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      sum_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      sum_valid_in = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit done;
      rst = 1'b1; sum_valid_in = 1'b0; sum_data_in = '0; sum_ready_out = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 16'(ready_in_s), 16'd0);
      chk("reset_valid", 16'(valid_out_s), 16'd0);
      chk("reset_data", data_out_s, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: plain sum, back to back
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      @(negedge clk);
      chk("t1_valid1", 16'(valid_out_s), 16'd1);
      chk("t1_sum1", data_out_s, 16'd10);
      @(posedge clk); #1;
      send(16'd10); send(16'd20); send(16'd30); send(16'd40);
      @(negedge clk);
      chk("t1_sum2", data_out_s, 16'd100);
      chk("t1_avg2", data_out_a, 16'd25);
      idle(2);

      // 2: saturation
      repeat (4) send(16'h7000);
      @(negedge clk);
      chk("t2_sat_pos", data_out_s, 16'h7FFF);
      chk("t2_avg_pos", data_out_a, 16'h7000);
      @(posedge clk); #1;
      repeat (4) send(16'h8000);
      @(negedge clk);
      chk("t2_sat_neg", data_out_s, 16'h8000);
      @(posedge clk); #1;

      // 3: average with floor rounding
      send(16'd5); send(16'd6); send(16'd7); send(16'd8);
      @(negedge clk);
      chk("t3_avg_pos", data_out_a, 16'd6);
      chk("t3_sum_pos", data_out_s, 16'd26);
      @(posedge clk); #1;
      send(-16'sd1); send(-16'sd1); send(-16'sd1); send(-16'sd2);
      @(negedge clk);
      chk("t3_avg_neg", data_out_a, -16'sd2);
      chk("t3_sum_neg", data_out_s, -16'sd5);
      @(posedge clk); #1;
      idle(2);

      // 4: backpressure
      sum_ready_out = 1'b0;
      for (int i = 1; i <= 7; i++) send(16'(i));
      sum_valid_in = 1'b1;
      sum_data_in  = 16'd8;
      repeat (3) begin
         @(negedge clk);
         chk("t4_stall_ready", 16'(ready_in_s), 16'd0);
         chk("t4_hold_valid", 16'(valid_out_s), 16'd1);
         chk("t4_hold_data", data_out_s, 16'd10);
      end
      @(posedge clk); #1;
      sum_ready_out = 1'b1;
      @(negedge clk);
      chk("t4_release_ready", 16'(ready_in_s), 16'd1);
      @(posedge clk); #1;
      sum_valid_in = 1'b0;
      @(negedge clk);
      chk("t4_second_valid", 16'(valid_out_s), 16'd1);
      chk("t4_second_data", data_out_s, 16'd26);
      @(posedge clk); #1;
      idle(2);

      // 5: gaps then reset discards partial window
      send(16'd100); idle(2); send(16'd200); idle(1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_ready", 16'(ready_in_s), 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      base = dut_xfers;
      send(16'd1); idle(1); send(16'd1); send(16'd1); idle(3); send(16'd1);
      @(negedge clk);
      chk("t5_result", data_out_s, 16'd4);
      @(posedge clk); #1;
      idle(3);
      chk("t5_count", 16'(dut_xfers - base), 16'd1);

      // 6: toggling downstream ready under continuous input
      base = dut_xfers;
      done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) send(16'($urandom));
            done = 1;
         end
         begin
            while (!done) begin
               sum_ready_out = ~sum_ready_out;
               @(posedge clk); #1;
            end
         end
      join
      sum_ready_out = 1'b1;
      idle(4);
      chk("t6_count", 16'(dut_xfers - base), 16'd10);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst           = ($urandom_range(199) == 0);
         sum_valid_in  = ($urandom_range(9) < 7);
         sum_ready_out = $urandom_range(1) == 1;
         case ($urandom_range(7))
            0: sum_data_in = 16'h7FFF;
            1: sum_data_in = 16'h8000;
            default: sum_data_in = 16'($urandom);
         endcase
         @(posedge clk); #1;
      end
      rst = 1'b0; sum_valid_in = 1'b0; sum_ready_out = 1'b1;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sum_pool.md
# sum_pool

Windowed accumulation stage placed directly downstream of the power stage in the 1D-CNN datapath. It consumes a stream of DATA_WIDTH samples over an AXI4-Stream-lite ready/valid interface and sums every POOL_SIZE consecutive accepted samples into one output word. The output is either the saturated sum or, with AVERAGE=1, the saturated mean. Together with the power stage, this forms the Lp/energy pooling path.

## Interface
- DATA_WIDTH, cnn1d_pkg::DATA_WIDTH: sample width; signed two's complement.
- POOL_SIZE, 4: samples per window, 2..256. Must be a power of 2 when AVERAGE=1.
- AVERAGE, 0: 0 outputs the sum; 1 outputs the sum arithmetic-shifted right by log2(POOL_SIZE).
- ACC_WIDTH (localparam): DATA_WIDTH + $clog2(POOL_SIZE). Internal accumulator width; no intermediate overflow is possible.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sum_ready_in  out  1  stage can accept a sample.
- sum_valid_in  in  1  upstream sample valid.
- sum_data_in  in  DATA_WIDTH  upstream sample.
- sum_ready_out  in  1  downstream accepts the result.
- sum_valid_out  out  1  result valid.
- sum_data_out  out  DATA_WIDTH  pooled result.

## Operation
- Input transfer: sum_valid_in & sum_ready_in on a rising edge. Output transfer: sum_valid_out & sum_ready_out.
- Internal state:
  - acc (ACC_WIDTH, signed)
  - cnt (0..POOL_SIZE-1)
  - output register: data + valid
- Input transfer with cnt < POOL_SIZE-1: acc <= acc + sext(sum_data_in); cnt <= cnt+1.
- Input transfer with cnt == POOL_SIZE-1 (window close):
  - total = acc + sext(sum_data_in).
  - Output register <= convert(total); sum_valid_out <= 1.
  - acc <= 0; cnt <= 0.
- convert():
  - If AVERAGE=1: shift total right arithmetically by log2(POOL_SIZE), truncating toward -inf.
  - Then saturate to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output transfer without a simultaneous window close: sum_valid_out <= 0. sum_data_out holds its last value.
- Output transfer and window close in the same cycle: the new result loads; sum_valid_out stays 1.
- Ready rule (combinational):
  - sum_ready_in = ~rst & ((cnt != POOL_SIZE-1) | ~sum_valid_out | sum_ready_out).
  - Mid-window samples are accepted while a result is still pending.
  - Only the window-closing sample stalls on downstream backpressure.
- sum_valid_in low: no state change except the output handshake. Gaps between samples do not break the window.
- While sum_valid_out=1 and sum_ready_out=0, sum_data_out and sum_valid_out are stable.

## Timing
- Reset values:
  - sum_valid_out=0, sum_data_out=0.
  - acc=0, cnt=0.
  - sum_ready_in=0 throughout reset; it may rise in the first cycle after rst deasserts.
- Reset mid-window discards the partial sum and any pending output. A result not yet accepted is lost.
- Latency: sum_valid_out rises one cycle after the window-closing input transfer.
- Throughput: one sample per cycle sustained when sum_ready_out=1. One result per POOL_SIZE samples.
- No combinational path from sum_valid_in or sum_data_in to any output. sum_ready_in depends combinationally on sum_ready_out.

## Test plan
1. Sum, no backpressure:
   - Setup: DATA_WIDTH=16, POOL_SIZE=4, AVERAGE=0, sum_ready_out=1.
   - Stimulus: inputs 1,2,3,4,10,20,30,40 on consecutive cycles.
   - Required: valid_out pulses with 10, then 100. Each pulse comes one cycle after the 4th and 8th transfers; sum_ready_in stays 1.
2. Saturation:
   - Stimulus: four inputs of 0x7000. Then four inputs of 0x8000 (-32768).
   - Required: first result 0x7FFF; second result 0x8000.
3. Average:
   - Setup: AVERAGE=1, POOL_SIZE=4.
   - Stimulus: inputs 5,6,7,8. Then inputs -1,-1,-1,-2.
   - Required: results 6 (26>>2) and -2 (-5>>>2).
4. Backpressure:
   - Setup: sum_ready_out=0; feed 8 samples continuously.
   - Required: the first result holds stable. Samples 5-7 are accepted. sum_ready_in drops at cnt=3 until sum_ready_out=1.
   - On release: the first result transfers, the 8th sample is accepted in the same cycle, and the second result is valid the next cycle.
5. Gaps and reset:
   - Stimulus: 2 samples with valid gaps, then rst for 1 cycle, then 4 samples of 1.
   - Required: ready_in=0 during rst. Exactly one result of 4; the pre-reset partial sum is discarded.
6. Back-to-back output handshake:
   - Setup: sum_ready_out toggles 1/0 every cycle while continuous input is applied.
   - Required: no result is lost or duplicated, and the result count equals inputs/4.
